// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and defaults for the vector-multiplier step sequencer.
// Optional feature macro used by the controller: CTRL_STALL_CNT_EN.
package ctrl_pkg;

   // Sequencer phases: waiting for a start, stepping, finished and waiting to re-arm.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int CNT_W_DEF      = 5;
   localparam int MAX_STATES_DEF = 24;

   // All-ones code of the given width; used as the not-running sentinel on state_count.
   function automatic int unsigned idle_code(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/ctrl_sat_counter.sv
// ctrl_sat_counter: saturating up-counter with synchronous clear.
// Instantiated by ctrl_seq_controller only when CTRL_STALL_CNT_EN is defined.
module ctrl_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   // Count increments, sticking at all-ones; clear has priority over increment.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ctrl_seq_controller.sv
// ctrl_seq_controller: step sequencer issuing state_count 0..last, one step per
// non-stalled cycle, with run-time length, one-shot or loop mode, stall and abort.
// Optional feature macro: CTRL_STALL_CNT_EN adds a saturating stall_cycles output.
//
// Handshake: start is a request sampled only in IDLE or DONE; it is accepted on
// the edge where it is seen high (and abort is low), and index 0 appears right
// after that edge. Completion is signalled by end_signal (level, held in DONE
// until the next accepted start or an abort) plus a one-cycle done_pulse on
// entry to DONE. start in RUN is ignored; abort always wins over start.
module ctrl_seq_controller
   import ctrl_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int MAX_STATES = MAX_STATES_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_last,
   input  logic             loop_mode,
   input  logic             stall,
   input  logic             abort,
   output logic [CNT_W-1:0] state_count,
   output logic             busy,
   output logic             end_signal,
   output logic             done_pulse,
   output logic             wrap_pulse,
`ifdef CTRL_STALL_CNT_EN
   output logic [15:0]      stall_cycles,
`endif
   output logic [1:0]       dbg_state
);

   // Sequence length must fit below the sentinel code.
   if ((MAX_STATES < 1) || (MAX_STATES > (2 ** CNT_W) - 1)) begin : g_param_check
      $error("ctrl_seq_controller: MAX_STATES must be in 1 .. 2**CNT_W-1");
   end

   localparam logic [CNT_W-1:0] IDLE_CODE = CNT_W'(idle_code(CNT_W));
   localparam logic [CNT_W-1:0] LAST_MAX  = CNT_W'(MAX_STATES - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] last_q;
   logic [CNT_W-1:0] last_d;
   logic             loop_q;
   logic             busy_q;
   logic             end_q;
   logic             done_q;
   logic             wrap_q;
   logic             start_ok;

   // Requested last index clamped to the longest supported sequence.
   assign last_d   = (cfg_last > LAST_MAX) ? LAST_MAX : cfg_last;

   // A start is taken only from IDLE/DONE and only when not overridden by abort.
   assign start_ok = start && !abort && (state_q != S_RUN);

   // Sequencer FSM and step counter; all outputs registered, pulses default low.
   always_ff @(posedge clk) begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= IDLE_CODE;
         last_q  <= '0;
         loop_q  <= 1'b0;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else if (abort) begin
         state_q <= S_IDLE;
         cnt_q   <= IDLE_CODE;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
                  last_q  <= last_d;
                  loop_q  <= loop_mode;
                  busy_q  <= 1'b1;
                  end_q   <= 1'b0;
               end
            end
            S_RUN: begin
               if (!stall) begin
                  if (cnt_q != last_q) begin
                     cnt_q <= cnt_q + 1'b1;
                  end else if (loop_q) begin
                     cnt_q  <= '0;
                     wrap_q <= 1'b1;
                  end else begin
                     state_q <= S_DONE;
                     cnt_q   <= IDLE_CODE;
                     busy_q  <= 1'b0;
                     end_q   <= 1'b1;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= IDLE_CODE;
               busy_q  <= 1'b0;
               end_q   <= 1'b0;
            end
         endcase
      end
   end

   assign state_count = cnt_q;
   assign busy        = busy_q;
   assign end_signal  = end_q;
   assign done_pulse  = done_q;
   assign wrap_pulse  = wrap_q;
   assign dbg_state   = state_q;

`ifdef CTRL_STALL_CNT_EN
   // Stalled RUN cycles of the current sequence; restarts on each accepted start.
   ctrl_sat_counter #(
      .WIDTH (16)
   ) u_stall_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (busy_q && stall && !abort),
      .clr   (start_ok),
      .count (stall_cycles)
   );
`else
   // Stall statistics not built in this configuration.
`endif

endmodule

// File: tb/tb_ctrl_seq_controller.sv
// tb_ctrl_seq_controller: directed scenarios plus randomized traffic against a
// behavioural model of the sequencer (length, loop, stall, abort, reset rules).
module tb_ctrl_seq_controller;
   import ctrl_pkg::*;

   localparam int CW   = 5;
   localparam int MAXS = 24;
   localparam int SENT = 31;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] cfg_last = '0;
   logic          loop_mode = 1'b0;
   logic          stall = 1'b0;
   logic          abort = 1'b0;
   logic [CW-1:0] state_count;
   logic          busy;
   logic          end_signal;
   logic          done_pulse;
   logic          wrap_pulse;
   logic [1:0]    dbg_state;
`ifdef CTRL_STALL_CNT_EN
   logic [15:0]   stall_cycles;
`endif

   always #5 clk = ~clk;

   ctrl_seq_controller #(.CNT_W(CW), .MAX_STATES(MAXS)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .cfg_last    (cfg_last),
      .loop_mode   (loop_mode),
      .stall       (stall),
      .abort       (abort),
      .state_count (state_count),
      .busy        (busy),
      .end_signal  (end_signal),
      .done_pulse  (done_pulse),
      .wrap_pulse  (wrap_pulse),
`ifdef CTRL_STALL_CNT_EN
      .stall_cycles(stall_cycles),
`endif
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   // packed expectation: {stall_cnt[15:0], busy, end, done, wrap, count[4:0]}
   logic [24:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_running = 0;
   bit m_end     = 0;
   bit m_loop    = 0;
   int m_idx     = 0;
   int m_last    = 0;
   int m_stalls  = 0;

   // Advance the model by one clock edge given this cycle's inputs; returns packed outputs.
   function automatic logic [24:0] model_edge(input bit st, input int cl, input bit lp,
                                              input bit sl, input bit ab, input bit rn);
      bit dp = 0;
      bit wp = 0;
      int shown;
      if (!rn) begin
         m_running = 0; m_end = 0; m_last = 0; m_loop = 0; m_stalls = 0;
      end else if (ab) begin
         m_running = 0; m_end = 0;
      end else if (!m_running) begin
         if (st) begin
            m_running = 1; m_end = 0; m_idx = 0; m_loop = lp; m_stalls = 0;
            m_last = (cl > MAXS - 1) ? MAXS - 1 : cl;
         end
      end else if (sl) begin
         if (m_stalls < 65535) m_stalls++;
      end else if (m_idx < m_last) begin
         m_idx++;
      end else if (m_loop) begin
         m_idx = 0; wp = 1;
      end else begin
         m_running = 0; m_end = 1; dp = 1;
      end
      shown = m_running ? m_idx : SENT;
      return {m_stalls[15:0], m_running, m_end, dp, wp, shown[4:0]};
   endfunction

   // ---------------- driver ----------------
   task automatic step(input bit st, input int cl, input bit lp, input bit sl,
                       input bit ab, input bit rn);
      logic [24:0] e;
      start = st; cfg_last = CW'(cl); loop_mode = lp; stall = sl; abort = ab; rstn = rn;
      exp_q.push_back(model_edge(st, cl, lp, sl, ab, rn));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_val("count", 32'(state_count), 32'(e[4:0]));
      check_val("busy",  32'(busy),        32'(e[8]));
      check_val("end",   32'(end_signal),  32'(e[7]));
      check_val("done",  32'(done_pulse),  32'(e[6]));
      check_val("wrap",  32'(wrap_pulse),  32'(e[5]));
`ifdef CTRL_STALL_CNT_EN
      check_val("stall_cycles", 32'(stall_cycles), 32'(e[24:9]));
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int cnt;
      int s2;
      int s4;
      bit sl;

      // reset (two cycles; the first establishes a known model state)
      start = 0; abort = 0; stall = 0; rstn = 0;
      void'(model_edge(0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      step(0, 0, 0, 0, 0, 0);
      check_val("rst_count", 32'(state_count), 32'(SENT));

      // one-shot full-length sequence
      step(1, 23, 0, 0, 0, 1);
      check_val("t1_first", 32'(state_count), 32'd0);
      cnt = 0;
      for (int i = 0; i < 26; i++) begin
         step(0, 23, 0, 0, 0, 1);
         if (done_pulse) cnt++;
      end
      check_val("t1_done_once", 32'(cnt), 32'd1);
      check_val("t1_end", 32'(end_signal), 32'd1);

      // short sequence with stalls at indices 2 and 4
      step(1, 5, 0, 0, 0, 1);
      n = 0; s2 = 0; s4 = 0;
      while (!end_signal && n < 50) begin
         sl = 0;
         if (m_idx == 2 && s2 < 3) begin sl = 1; s2++; end
         if (m_idx == 4 && s4 < 3) begin sl = 1; s4++; end
         step(0, 5, 0, sl, 0, 1);
         n++;
      end
      check_val("t2_cycles_to_done", 32'(n), 32'd12);
`ifdef CTRL_STALL_CNT_EN
      check_val("t2_stall_cycles", 32'(stall_cycles), 32'd6);
`endif

      // over-range length clamps to MAX_STATES-1
      step(1, 30, 0, 0, 0, 1);
      n = 0;
      while (!end_signal && n < 50) begin
         step(0, 30, 0, 0, 0, 1);
         n++;
      end
      check_val("t3_clamp_cycles", 32'(n), 32'd24);

      // loop mode with wraps, then abort at index 2
      step(1, 3, 1, 0, 0, 1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 7, 0, 0, 0, 1);
         if (wrap_pulse) cnt++;
      end
      check_val("t4_wraps", 32'(cnt), 32'd2);
      check_val("t4_at2", 32'(state_count), 32'd2);
      step(0, 3, 0, 0, 1, 1);
      check_val("t4_abort_count", 32'(state_count), 32'(SENT));
      check_val("t4_abort_end", 32'(end_signal), 32'd0);
      step(0, 3, 0, 0, 0, 1);

      // start held high: no mid-run restart, immediate re-arm after DONE
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 2, 0, 0, 0, 1);
         if (done_pulse) cnt++;
      end
      check_val("t5_done_once", 32'(cnt), 32'd1);
      check_val("t5_rearm", 32'(state_count), 32'd0);
      step(0, 2, 0, 0, 1, 1);

      // reset mid-run at index 10, then start+abort from IDLE
      step(1, 23, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 23, 0, 0, 0, 1);
      check_val("t6_at10", 32'(state_count), 32'd10);
      step(0, 23, 0, 0, 0, 0);
      check_val("t6_rst_busy", 32'(busy), 32'd0);
      step(1, 4, 0, 0, 1, 1);
      step(0, 4, 0, 0, 0, 1);
      check_val("t6_idle_after_abort", 32'(state_count), 32'(SENT));

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 3,
              int'($urandom_range(0, 31)),
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 199) != 0);
      end

      check_val("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ctrl_seq_controller.md
Name: ctrl_seq_controller

Overview:
Parametrised step sequencer for the vector-multiplier datapath. It issues a state index 0..N-1, one step per enabled cycle, and replaces the fixed 24-step one-shot controller. Additions over that controller:
- run-time sequence length
- start/done handshake with re-arm
- datapath stall (hold)
- abort
- continuous (loop) mode
Sits between the top-level host interface and the datapath muxes/accumulators that decode state_count.

Parameters:
CNT_W, 5, width of state_count; all-ones code (2**CNT_W-1) is reserved as the idle/finished sentinel.
MAX_STATES, 24, maximum sequence length; constraint 1 <= MAX_STATES <= 2**CNT_W-1 (checked by elaboration-time assertion).

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  synchronous active-low reset.
start  input  1  request a new sequence; sampled only in IDLE or DONE.
cfg_last  input  CNT_W  last index of the sequence (length-1); latched on accepted start.
loop_mode  input  1  1 = wrap to 0 after last index instead of finishing; latched on accepted start.
stall  input  1  hold current index this cycle (datapath back-pressure).
abort  input  1  terminate any sequence immediately.
state_count  output  CNT_W  current step index; sentinel all-ones when not running.
busy  output  1  high in RUN.
end_signal  output  1  level; high in DONE until next accepted start or abort.
done_pulse  output  1  one-cycle pulse on entry to DONE.
wrap_pulse  output  1  one-cycle pulse on each loop-mode wrap.

Behaviour:
- Reset (rstn=0 at clk edge): state IDLE, state_count=all-ones, busy=0, end_signal=0, done_pulse=0, wrap_pulse=0, latched cfg cleared to 0.
- All outputs registered. done_pulse and wrap_pulse default to 0 every cycle.
- States: IDLE, RUN, DONE.
- Priority per cycle: rstn > abort > start > stall > count.
- IDLE/DONE + start=1:
  - Latch last = min(cfg_last, MAX_STATES-1) and loop_mode.
  - Next cycle: RUN, state_count=0, busy=1, end_signal=0.
  - Latency: start sampled at edge k, index 0 visible after edge k.
- RUN, stall=1: state_count holds; no pulses.
- RUN, stall=0, state_count<last: state_count+1.
- RUN, stall=0, state_count==last:
  - loop=0: go to DONE, state_count=all-ones, busy=0, end_signal=1, done_pulse=1.
  - loop=1: state_count=0, wrap_pulse=1, stay RUN.
- last=0 (length 1): index 0 is shown for one enabled cycle, then DONE (or wrap every enabled cycle in loop mode).
- start while in RUN: ignored. Latched cfg_last and loop_mode are not updated mid-run.
- abort (any state): next cycle IDLE, state_count=all-ones, busy=0, end_signal=0, no done_pulse. abort and start in the same cycle: abort wins and start is dropped.
- DONE: holds end_signal=1 and the sentinel indefinitely. start re-arms directly; no pass through IDLE.
- Loop mode ends only via abort.
- Reset mid-run: identical to power-up reset on the next edge.
- Counter never exceeds last, and never emits the sentinel while busy.

Optional Feature:
Macro CTRL_STALL_CNT_EN.
- Defined: adds output stall_cycles (16 bits).
  - Counts RUN cycles with stall=1; saturates at 16'hFFFF.
  - Cleared on accepted start and on reset; holds its value in DONE/IDLE.
- Undefined: port and logic absent. Core behaviour is identical either way.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - localparam defaults for CNT_W and MAX_STATES
  - function idle_code(CNT_W) returning all-ones
- No sub-module for the core FSM/counter.
- When CTRL_STALL_CNT_EN is defined, the saturating counter is a natural sub-module: ctrl_sat_counter (WIDTH param, inc/clr inputs).

Test Plan:
- Defaults, cfg_last=23, loop=0, one-cycle start, stall=0: state_count 0..23 over 24 cycles; then 31, end_signal=1, done_pulse high exactly 1 cycle, busy=0.
- cfg_last=5, stall asserted at indices 2 and 4 for 3 cycles each: index holds those cycles; DONE 12 cycles after start; stall_cycles=6 if CTRL_STALL_CNT_EN.
- cfg_last=30 (>MAX_STATES-1): clamps; sequence runs 0..23 then DONE.
- loop=1, cfg_last=3: 0,1,2,3,0,1,… with wrap_pulse on each 3→0. Abort at index 2 → next cycle state_count=31, busy=0, end_signal=0, no done_pulse.
- Start held high throughout a run with cfg_last=2: run is not restarted mid-sequence; DONE entered once, then immediately re-armed (index 0 the cycle after DONE).
- rstn=0 for one cycle at index 10: next cycle all outputs at reset values. start plus abort together from IDLE: remains IDLE.
